// File: rtl/dma_csr_axil_slave_if.sv
// AXI4-Lite bus bundle shared by the SoC interconnect and its CSR responders.
// Slave modport is the responder view; Master modport is the requester view.
interface AXILiteIntf;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport Slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/dma_csr_axil_slave.sv
// AXI4-Lite CSR block for the DMA engine: CTRL/STATUS/SRC/DST/LENGTH/ID map.
// Define DMA_CSR_PROT_CHECK_EN to reject unprivileged writes to RW/W1C registers.
module dma_csr_axil_slave #(
    parameter logic [31:0] ID_VALUE = 32'h444D_4101
) (
    input  logic        ACLK,
    input  logic        ARESET,
    AXILiteIntf.Slave   s_axil,
    input  logic        busy_i,
    input  logic        done_i,
    input  logic        err_i,
    output logic        enable_o,
    output logic        start_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [31:0] length_o,
    output logic        irq_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic        aw_held, w_held;
    logic [2:0]  aw_sel;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        enable, irq_en, done, err, start;
    logic [31:0] src_addr, dst_addr, length;
    logic        aw_hs, w_hs, ar_hs;
    logic        commit, priv, wr_en, clr_done, clr_err;
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_data;
    logic        unused_bits;

`ifdef DMA_CSR_PROT_CHECK_EN
    logic aw_priv;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = data[i*8 +: 8];
        end
        return res;
    endfunction

    assign s_axil.awready = !aw_held && !bvalid;
    assign s_axil.wready  = !w_held && !bvalid;
    assign s_axil.arready = !rvalid;
    assign s_axil.bvalid  = bvalid;
    assign s_axil.bresp   = bresp;
    assign s_axil.rvalid  = rvalid;
    assign s_axil.rresp   = rresp;
    assign s_axil.rdata   = rdata;

    assign aw_hs = s_axil.awvalid && !aw_held && !bvalid;
    assign w_hs  = s_axil.wvalid && !w_held && !bvalid;
    assign ar_hs = s_axil.arvalid && !rvalid;

    assign enable_o   = enable;
    assign start_o    = start;
    assign src_addr_o = src_addr;
    assign dst_addr_o = dst_addr;
    assign length_o   = length;
    assign irq_o      = irq_en && (done || err);

    assign unused_bits = ^{s_axil.awaddr[31:5], s_axil.awaddr[1:0], s_axil.awprot,
                           s_axil.araddr[31:5], s_axil.araddr[1:0], s_axil.arprot};

    // Commit decode: RO/ID writes complete OKAY with no effect; unmapped and
    // (optionally) unprivileged writes to mutable registers complete SLVERR.
    always_comb begin
        commit = aw_held && w_held;
        priv   = 1'b1;
`ifdef DMA_CSR_PROT_CHECK_EN
        priv   = aw_priv;
`endif
        wr_en  = commit && (aw_sel <= 3'd4) && priv;
        if (aw_sel >= 3'd6 || (aw_sel <= 3'd4 && !priv)) wr_resp = RESP_SLVERR;
        else                                             wr_resp = RESP_OKAY;
        clr_done = wr_en && (aw_sel == 3'd1) && w_strb[0] && w_data[1];
        clr_err  = wr_en && (aw_sel == 3'd1) && w_strb[0] && w_data[2];
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (s_axil.araddr[4:2])
            3'd0:    rd_data = {29'b0, irq_en, 1'b0, enable};
            3'd1:    rd_data = {29'b0, err, done, busy_i};
            3'd2:    rd_data = src_addr;
            3'd3:    rd_data = dst_addr;
            3'd4:    rd_data = length;
            3'd5:    rd_data = ID_VALUE;
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_sel   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            start    <= 1'b0;
            src_addr <= '0;
            dst_addr <= '0;
            length   <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_sel  <= s_axil.awaddr[4:2];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_axil.wdata;
                w_strb <= s_axil.wstrb;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_resp;
            end else if (bvalid && s_axil.bready) begin
                bvalid <= 1'b0;
            end

            start <= wr_en && (aw_sel == 3'd0) && w_strb[0] && w_data[1];
            if (wr_en) begin
                case (aw_sel)
                    3'd0: if (w_strb[0]) begin
                        enable <= w_data[0];
                        irq_en <= w_data[2];
                    end
                    3'd2:    src_addr <= merge(src_addr, w_data, w_strb);
                    3'd3:    dst_addr <= merge(dst_addr, w_data, w_strb);
                    3'd4:    length   <= merge(length, w_data, w_strb);
                    default: ;
                endcase
            end
            // Event set takes priority over a same-cycle W1C clear.
            done <= done_i || (done && !clr_done);
            err  <= err_i || (err && !clr_err);

            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
                rresp  <= rd_resp;
            end else if (rvalid && s_axil.rready) begin
                rvalid <= 1'b0;
            end
        end
    end

`ifdef DMA_CSR_PROT_CHECK_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)     aw_priv <= 1'b0;
        else if (aw_hs) aw_priv <= s_axil.awprot[0];
    end
`endif
endmodule

// File: tb/tb_dma_csr_axil_slave.sv
// Self-checking bench for dma_csr_axil_slave: directed register-map checks
// followed by randomized writes/reads compared against a register-level model.
module tb_dma_csr_axil_slave;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        busy_i = 1'b0, done_i = 1'b0, err_i = 1'b0;
    logic        enable_o, start_o, irq_o;
    logic [31:0] src_addr_o, dst_addr_o, length_o;

    AXILiteIntf axil();

    dma_csr_axil_slave #(.ID_VALUE(32'h444D_4101)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axil(axil),
        .busy_i(busy_i), .done_i(done_i), .err_i(err_i),
        .enable_o(enable_o), .start_o(start_o), .src_addr_o(src_addr_o),
        .dst_addr_o(dst_addr_o), .length_o(length_o), .irq_o(irq_o)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    // Reference model state: register contents as software sees them.
    logic        m_en, m_irqen, m_done, m_err;
    logic [31:0] m_rw [2:4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_done = 0; m_err = 0;
        for (int i = 2; i <= 4; i++) m_rw[i] = '0;
    endtask

    task automatic model_read(input logic [2:0] idx, output logic [31:0] data,
                              output logic [1:0] resp);
        resp = 2'b00;
        data = '0;
        case (idx)
            3'd0:       data = {29'b0, m_irqen, 1'b0, m_en};
            3'd1:       data = {29'b0, m_err, m_done, busy_i};
            3'd2, 3'd3, 3'd4: data = m_rw[idx];
            3'd5:       data = 32'h444D_4101;
            default:    resp = 2'b10;
        endcase
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [2:0] prot,
                               output logic [1:0] resp, output logic start);
        logic [2:0]  idx;
        logic        priv;
        logic [31:0] mask;
        idx   = addr[4:2];
        priv  = 1'b1;
`ifdef DMA_CSR_PROT_CHECK_EN
        priv  = prot[0];
`endif
        mask  = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        resp  = 2'b00;
        start = 1'b0;
        if (idx >= 3'd6 || (idx <= 3'd4 && !priv)) resp = 2'b10;
        else if (idx == 3'd0) begin
            if (strb[0]) begin m_en = data[0]; m_irqen = data[2]; start = data[1]; end
        end else if (idx == 3'd1) begin
            if (strb[0] && data[1]) m_done = 1'b0;
            if (strb[0] && data[2]) m_err = 1'b0;
        end else if (idx <= 3'd4) begin
            m_rw[idx] = (m_rw[idx] & ~mask) | (data & mask);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_enable"}, 32'(enable_o), 32'(m_en));
        check({tag, "_irq"}, 32'(irq_o), 32'(m_irqen & (m_done | m_err)));
        check({tag, "_src"}, src_addr_o, m_rw[2]);
        check({tag, "_dst"}, dst_addr_o, m_rw[3]);
        check({tag, "_len"}, length_o, m_rw[4]);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [2:0] prot,
                             input bit done_at_commit, input int w_lead);
        logic [1:0] exp_resp;
        logic       exp_start;
        bit         aw_fire, w_fire, aw_sent;
        int         t;
        model_write(addr, data, strb, prot, exp_resp, exp_start);
        if (done_at_commit) m_done = 1'b1;
        axil.awaddr = addr; axil.awprot = prot;
        axil.wdata = data;  axil.wstrb = strb;
        axil.wvalid = 1'b1;
        aw_sent = (w_lead == 0);
        axil.awvalid = aw_sent;
        t = 0;
        while ((axil.awvalid || axil.wvalid || !aw_sent) && t < 50) begin
            aw_fire = axil.awvalid && axil.awready;
            w_fire  = axil.wvalid && axil.wready;
            step();
            t++;
            if (aw_fire) axil.awvalid = 1'b0;
            if (w_fire)  axil.wvalid = 1'b0;
            if (!aw_sent && t >= w_lead) begin axil.awvalid = 1'b1; aw_sent = 1'b1; end
        end
        check("wr_handshake_timeout", 32'(t < 50), 32'd1);
        check("b_early", 32'(axil.bvalid), 32'd0);
        if (done_at_commit) done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("b_latency", 32'(axil.bvalid), 32'd1);
        check("bresp", 32'(axil.bresp), 32'(exp_resp));
        check("start_pulse", 32'(start_o), 32'(exp_start));
        axil.bready = 1'b1;
        step();
        axil.bready = 1'b0;
        check("start_clear", 32'(start_o), 32'd0);
        check("b_clear", 32'(axil.bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input string tag);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          t;
        axil.araddr = addr; axil.arprot = 3'($urandom);
        axil.arvalid = 1'b1;
        t = 0;
        while (!axil.arready && t < 50) begin step(); t++; end
        check({tag, "_ar_timeout"}, 32'(t < 50), 32'd1);
        model_read(addr[4:2], exp_data, exp_resp);
        step();
        axil.arvalid = 1'b0;
        check({tag, "_rvalid"}, 32'(axil.rvalid), 32'd1);
        check({tag, "_rdata"}, axil.rdata, exp_data);
        check({tag, "_rresp"}, 32'(axil.rresp), 32'(exp_resp));
        step();
        check({tag, "_rdata_hold"}, axil.rdata, exp_data);
        axil.rready = 1'b1;
        step();
        axil.rready = 1'b0;
        check({tag, "_rvalid_clear"}, 32'(axil.rvalid), 32'd0);
    endtask

    task automatic pulse(input logic d, input logic e);
        done_i = d; err_i = e;
        step();
        done_i = 1'b0; err_i = 1'b0;
        if (d) m_done = 1'b1;
        if (e) m_err = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr, data;
        axil.awaddr = '0; axil.awprot = '0; axil.awvalid = 0;
        axil.wdata = '0;  axil.wstrb = '0;  axil.wvalid = 0; axil.bready = 0;
        axil.araddr = '0; axil.arprot = '0; axil.arvalid = 0; axil.rready = 0;
        model_reset();
        step(); step();
        // Reset state
        check("rst_awready", 32'(axil.awready), 32'd1);
        check("rst_wready", 32'(axil.wready), 32'd1);
        check("rst_arready", 32'(axil.arready), 32'd1);
        check("rst_bvalid", 32'(axil.bvalid), 32'd0);
        check("rst_rvalid", 32'(axil.rvalid), 32'd0);
        check("rst_bresp", 32'(axil.bresp), 32'd0);
        check("rst_rresp", 32'(axil.rresp), 32'd0);
        check("rst_rdata", axil.rdata, 32'd0);
        check("rst_start", 32'(start_o), 32'd0);
        check_outputs("rst");
        ARESET = 1'b0;
        step();

        axi_read(32'h14, "id");
        axi_read(32'h08, "src_init");

        // W leads AW by three cycles, then a single-byte strobe merge
        axi_write(32'h08, 32'hDEAD_BEEF, 4'hF, 3'b001, 0, 3);
        check("src_full", src_addr_o, 32'hDEAD_BEEF);
        axi_write(32'h08, 32'h0000_5500, 4'h2, 3'b001, 0, 0);
        check("src_strb", src_addr_o, 32'hDEAD_55EF);

        axi_write(32'h00, 32'h7, 4'hF, 3'b001, 0, 0);
        check("ctrl_enable", 32'(enable_o), 32'd1);
        axi_read(32'h00, "ctrl_rb");

        pulse(1'b1, 1'b0);
        check("irq_on_done", 32'(irq_o), 32'd1);
        axi_read(32'h04, "status_done");
        axi_write(32'h04, 32'h2, 4'hF, 3'b001, 1, 0);
        check("done_set_wins", 32'(irq_o), 32'd1);
        axi_read(32'h04, "status_setwins");
        axi_write(32'h04, 32'h2, 4'hF, 3'b001, 0, 0);
        check("done_cleared_irq", 32'(irq_o), 32'd0);
        axi_read(32'h04, "status_cleared");

        axi_read(32'h1C, "unmapped_rd");
        axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, 3'b001, 0, 0);
        check_outputs("unmapped_wr");

        // BREADY held low: response must persist and block new AW
        axil.awaddr = 32'h18; axil.awprot = 3'b001; axil.awvalid = 1;
        axil.wdata = 32'h1234_5678; axil.wstrb = 4'hF; axil.wvalid = 1;
        step();
        axil.awvalid = 0; axil.wvalid = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid", 32'(axil.bvalid), 32'd1);
            check("bhold_awready", 32'(axil.awready), 32'd0);
            step();
        end
        check("bhold_bresp", 32'(axil.bresp), 32'd2);
        axil.bready = 1'b1;
        step();
        axil.bready = 1'b0;
        check("bhold_release", 32'(axil.bvalid), 32'd0);

        axi_write(32'h10, 32'hCAFE_0001, 4'hF, 3'b000, 0, 0);
        axi_write(32'h10, 32'hCAFE_0002, 4'hF, 3'b001, 0, 1);
        check("len_priv_write", length_o, 32'hCAFE_0002);

        // Randomized traffic with stray address bits and random strobes/prot
        for (int n = 0; n < 40; n++) begin
            busy_i = 1'($urandom);
            if ($urandom_range(0, 3) == 0) pulse(1'($urandom), 1'($urandom));
            addr = $urandom;
            data = $urandom;
            axi_write(addr, data, 4'($urandom), 3'($urandom), 0, $urandom_range(0, 2));
            check_outputs("rnd");
            addr = $urandom;
            axi_read(addr, "rnd_rd");
        end

        // Reset with AW captured and a read response pending
        axil.awaddr = 32'h0C; axil.awprot = 3'b001; axil.awvalid = 1;
        axil.araddr = 32'h14; axil.arvalid = 1;
        step();
        axil.awvalid = 0; axil.arvalid = 0;
        check("pre_rst_rvalid", 32'(axil.rvalid), 32'd1);
        ARESET = 1'b1;
        #2;
        model_reset();
        check("mid_rst_rvalid", 32'(axil.rvalid), 32'd0);
        check("mid_rst_awready", 32'(axil.awready), 32'd1);
        check_outputs("mid_rst");
        step();
        ARESET = 1'b0;
        step();
        check("post_rst_wready", 32'(axil.wready), 32'd1);
        axi_write(32'h0C, 32'hA5A5_0F0F, 4'h5, 3'b001, 0, 0);
        check_outputs("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
